// File: rtl/shift_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and a
// compile-time log2 helper used to size the pipeline.
package shift_pipe_pkg;

    localparam logic [1:0] MODE_SHL = 2'b00;
    localparam logic [1:0] MODE_SHR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    // Ceiling log2 for elaboration-time sizing
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One level of the barrel shifter: conditional shift by 2^K, then register.
// Rotate path is compiled only when SHIFT_PIPE_ROTATE_EN is defined; otherwise
// mode 11 falls into the logical-right branch.
module shift_pipe_stage
    import shift_pipe_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned LOG2W     = 5,
    parameter int unsigned K         = 0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 advance,
    input  logic                 valid_in,
    input  logic [DATAWIDTH-1:0] data_in,
    input  logic [1:0]           mode_in,
    input  logic                 sign_in,
    input  logic [LOG2W-1:0]     amt_in,
    output logic                 valid_out,
    output logic [DATAWIDTH-1:0] data_out,
    output logic [1:0]           mode_out,
    output logic                 sign_out,
    output logic [LOG2W-1:0]     amt_out
);

    localparam int unsigned SHIFT = 1 << K;

    logic [DATAWIDTH-1:0] shr_c;
    logic [DATAWIDTH-1:0] fill_c;
    logic [DATAWIDTH-1:0] shifted_c;

    // Shift by 2^K when this level's amount bit is set
    always_comb begin
        shr_c     = data_in >> SHIFT;
        fill_c    = sign_in ? ~({DATAWIDTH{1'b1}} >> SHIFT) : '0;
        shifted_c = data_in;
        if (amt_in[K]) begin
            case (mode_in)
                MODE_SHL: shifted_c = data_in << SHIFT;
                MODE_ASR: shifted_c = shr_c | fill_c;
`ifdef SHIFT_PIPE_ROTATE_EN
                MODE_ROR: shifted_c = shr_c | (data_in << (DATAWIDTH - SHIFT));
`endif
                default:  shifted_c = shr_c;
            endcase
        end
    end

    // Stage register; holds everything while the pipe is stalled
    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            mode_out  <= '0;
            sign_out  <= 1'b0;
            amt_out   <= '0;
        end else if (advance) begin
            valid_out <= valid_in;
            data_out  <= shifted_c;
            mode_out  <= mode_in;
            sign_out  <= sign_in;
            amt_out   <= amt_in;
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SHL / SHR / ASR / optional ROR) with valid/ready
// handshake and a global stall. Latency is LOG2W cycles.
// Optional feature macro: SHIFT_PIPE_ROTATE_EN enables rotate-right on mode 11;
// without it, mode 11 behaves as logical right shift.
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned LOG2W     = clog2(DATAWIDTH)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] sh_amt,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] d
);

    logic                 advance;
    logic                 ovr_c;
    logic                 rotate_c;
    logic [DATAWIDTH-1:0] data_d;
    logic [LOG2W-1:0]     amt_d;

    logic                 valid_s [LOG2W];
    logic [DATAWIDTH-1:0] data_s  [LOG2W];
    logic [1:0]           mode_s  [LOG2W];
    logic                 sign_s  [LOG2W];
    logic [LOG2W-1:0]     amt_s   [LOG2W];

    // Global stall: the whole pipe moves only when the output slot can drain
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Input decode: over-range amounts collapse to a saturated operand with zero shift
    always_comb begin
        ovr_c = |sh_amt[DATAWIDTH-1:LOG2W];
`ifdef SHIFT_PIPE_ROTATE_EN
        rotate_c = (mode == MODE_ROR);
`else
        rotate_c = 1'b0;
`endif
        data_d = a;
        amt_d  = sh_amt[LOG2W-1:0];
        if (ovr_c && !rotate_c) begin
            amt_d  = '0;
            data_d = (mode == MODE_ASR) ? {DATAWIDTH{a[DATAWIDTH-1]}} : '0;
        end
    end

    // One stage per amount bit, level k shifts by 2^k
    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        if (k == 0) begin : g_first
            shift_pipe_stage #(
                .DATAWIDTH (DATAWIDTH),
                .LOG2W     (LOG2W),
                .K         (0)
            ) u_stage (
                .Clk       (Clk),
                .Rst       (Rst),
                .advance   (advance),
                .valid_in  (in_valid),
                .data_in   (data_d),
                .mode_in   (mode),
                .sign_in   (a[DATAWIDTH-1]),
                .amt_in    (amt_d),
                .valid_out (valid_s[0]),
                .data_out  (data_s[0]),
                .mode_out  (mode_s[0]),
                .sign_out  (sign_s[0]),
                .amt_out   (amt_s[0])
            );
        end else begin : g_next
            shift_pipe_stage #(
                .DATAWIDTH (DATAWIDTH),
                .LOG2W     (LOG2W),
                .K         (k)
            ) u_stage (
                .Clk       (Clk),
                .Rst       (Rst),
                .advance   (advance),
                .valid_in  (valid_s[k-1]),
                .data_in   (data_s[k-1]),
                .mode_in   (mode_s[k-1]),
                .sign_in   (sign_s[k-1]),
                .amt_in    (amt_s[k-1]),
                .valid_out (valid_s[k]),
                .data_out  (data_s[k]),
                .mode_out  (mode_s[k]),
                .sign_out  (sign_s[k]),
                .amt_out   (amt_s[k])
            );
        end
    end

    assign out_valid = valid_s[LOG2W-1];
    assign d         = data_s[LOG2W-1];

    // Control fields of the last stage have no consumer
    logic unused_tail;
    assign unused_tail = ^{amt_s[LOG2W-1], mode_s[LOG2W-1], sign_s[LOG2W-1]};

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe (DATAWIDTH=32): directed cases, backpressure, mid-flight
// reset and a randomized stream checked against a behavioural shift model.
module tb_shift_pipe;

    logic        Clk;
    logic        Rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] sh_amt;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned pops  = 0;
    logic [31:0] exp_q[$];

    shift_pipe #(.DATAWIDTH(32)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .sh_amt    (sh_amt),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Behavioural reference: the shift as plain arithmetic on the full amount
    function automatic logic [31:0] model(input logic [31:0] av, input logic [31:0] amtv,
                                          input logic [1:0] mv);
        int unsigned n;
        int unsigned r;
        n = amtv;
        r = n % 32;
        case (mv)
            2'd0: return (n >= 32) ? 32'd0 : (av << n);
            2'd2: return (n >= 32) ? {32{av[31]}} : 32'($signed(av) >>> n);
`ifdef SHIFT_PIPE_ROTATE_EN
            2'd3: return (r == 0) ? av : ((av >> r) | (av << (32 - r)));
`endif
            default: return (n >= 32) ? 32'd0 : (av >> n);
        endcase
    endfunction

    // Scoreboard: record accepted beats, compare every delivered result in order
    always @(negedge Clk) begin
        if (Rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", 32'd1, 32'd0);
                end else begin
                    check("sb_data", d, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, sh_amt, mode));
            end
        end
    end

    // Offer one beat and hold it until accepted; call at #1 after a rising edge
    task automatic push_beat(input logic [31:0] av, input logic [31:0] amtv, input logic [1:0] mv);
        int   guard;
        logic rdy;
        guard = 0;
        in_valid = 1'b1;
        a = av;
        sh_amt = amtv;
        mode = mv;
        do begin
            #1;
            rdy = in_ready;
            @(posedge Clk);
            #1;
            guard++;
        end while (!rdy && guard < 200);
        if (!rdy) check("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // Single beat into an empty pipe with out_ready=1: check value and latency
    task automatic send_one(input string tag, input logic [31:0] av, input logic [31:0] amtv,
                            input logic [1:0] mv, input logic [31:0] expv);
        int lat;
        out_ready = 1'b1;
        push_beat(av, amtv, mv);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd5);
        check(tag, d, expv);
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] rand_amt();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return $urandom();
            2:       return 32'($urandom_range(32, 40));
            default: return 32'($urandom_range(0, 31));
        endcase
    endfunction

    logic [31:0] held;
    logic [31:0] bp_a   [8];
    logic [31:0] bp_amt [8];
    logic [1:0]  bp_mode[8];
    logic        pending;
    logic        rdy;
    int unsigned pops_before;
    int unsigned seen_valid;
    int          guard;

    initial begin
        Rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        sh_amt = '0;
        mode = '0;
        out_ready = 1'b0;

        // Reset state, including a beat offered during reset that must be dropped
        @(posedge Clk);
        #1;
        in_valid = 1'b1;
        a = 32'hDEADBEEF;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d", d, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        Rst = 1'b0;
        out_ready = 1'b1;
        repeat (8) begin
            @(posedge Clk);
            #1;
            if (out_valid) check("rst_beat_leaked", 32'd1, 32'd0);
        end

        // Directed cases
        send_one("shr_4",    32'hF0000000, 32'd4,  2'b01, 32'h0F000000);
        send_one("shr_0",    32'hF0000000, 32'd0,  2'b01, 32'hF0000000);
        send_one("asr_40",   32'h80000000, 32'd40, 2'b10, 32'hFFFFFFFF);
        send_one("asr_31",   32'h80000000, 32'd31, 2'b10, 32'hFFFFFFFF);
        send_one("asr_1",    32'h80000000, 32'd1,  2'b10, 32'hC0000000);
        send_one("shl_31",   32'h00000001, 32'd31, 2'b00, 32'h80000000);
        send_one("shl_32",   32'h00000001, 32'd32, 2'b00, 32'h00000000);
        send_one("asr_pos_big", 32'h7FFFFFFF, 32'h80000000, 2'b10, 32'h00000000);
        send_one("shl_0",    32'h12345678, 32'd0,  2'b00, 32'h12345678);
`ifdef SHIFT_PIPE_ROTATE_EN
        send_one("ror_33",   32'h00000001, 32'd33, 2'b11, 32'h80000000);
        send_one("ror_8",    32'h000000AB, 32'd8,  2'b11, 32'hAB000000);
`else
        send_one("ror_33",   32'h00000001, 32'd33, 2'b11, 32'h00000000);
        send_one("ror_8",    32'h000000AB, 32'd8,  2'b11, 32'h00000000);
`endif

        // Backpressure: fill the pipe with out_ready low, hold, then release
        for (int i = 0; i < 8; i++) begin
            bp_a[i]    = $urandom();
            bp_amt[i]  = rand_amt();
            bp_mode[i] = 2'($urandom_range(0, 3));
        end
        pops_before = pops;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_beat(bp_a[i], bp_amt[i], bp_mode[i]);
        check("bp_full_out_valid", 32'(out_valid), 32'd1);
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        a = bp_a[5];
        sh_amt = bp_amt[5];
        mode = bp_mode[5];
        held = d;
        repeat (10) begin
            @(posedge Clk);
            #1;
            check("bp_hold_d", d, held);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        for (int i = 5; i < 8; i++) push_beat(bp_a[i], bp_amt[i], bp_mode[i]);
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge Clk);
            #1;
            guard++;
        end
        check("bp_drain_empty", 32'(exp_q.size()), 32'd0);
        check("bp_result_count", 32'(pops - pops_before), 32'd8);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) push_beat($urandom(), rand_amt(), 2'($urandom_range(0, 3)));
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_d", d, 32'd0);
        seen_valid = 0;
        repeat (8) begin
            @(posedge Clk);
            #1;
            if (out_valid) seen_valid++;
        end
        check("midrst_no_stale", 32'(seen_valid), 32'd0);
        send_one("post_rst_asr_1", 32'h80000000, 32'd1, 2'b10, 32'hC0000000);

        // Randomized stream with random idle input and random output stalls
        pending = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!pending) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    a = $urandom();
                    sh_amt = rand_amt();
                    mode = 2'($urandom_range(0, 3));
                    pending = 1'b1;
                end else begin
                    in_valid = 1'b0;
                    a = $urandom();
                    sh_amt = $urandom();
                    mode = 2'($urandom_range(0, 3));
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            rdy = in_ready;
            if (out_valid && !out_ready) held = d;
            @(posedge Clk);
            #1;
            if (rdy !== 1'b1 && out_valid) check("rand_stall_d", d, held);
            if (pending && rdy) pending = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge Clk);
            #1;
            guard++;
        end
        check("rand_drain_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
